// File: rtl/epl_serial_host.sv
// EPL serial bus host: turns single-beat register read/write requests into
// framed SCLK/SDI/SLE transactions and returns read data or a timeout flag.
module epl_serial_host #(
  parameter int CLK_DIV = 4,    // clk cycles per SCLK half-period (3..255)
  parameter int TIMEOUT = 1024  // max clk cycles in WAIT_RDY (1..65535)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        EPL_SCLK,
  output logic        EPL_SDI,
  input  logic        EPL_SDO,
  output logic        EPL_SLE,
  input  logic        EPL_SRDY
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, WAIT_RDY, RDATA, DONE, GAP} state_t;

  // Phase counter runs 0..2*CLK_DIV-1 inside one bit; SCLK is high for the
  // upper half. PH_RISE is the phase after which SCLK goes high.
  localparam logic [8:0]  PH_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0]  PH_RISE = 9'(CLK_DIV - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [8:0]  ph;
  logic [5:0]  bit_cnt;
  logic [15:0] to_cnt;
  logic [31:0] sh;        // tx: bits still to send (MSB next); rx: bits received
  logic [31:0] wdata_q;
  logic        write_q;
  logic [1:0]  sdo_sync;
  logic [1:0]  srdy_sync;
  logic        sdo_s;
  logic        srdy_s;
  logic        ph_end;

  assign sdo_s     = sdo_sync[1];
  assign srdy_s    = srdy_sync[1];
  assign ph_end    = (ph == PH_LAST);
  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  // Two-flop synchronizers for the asynchronous device-side inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sdo_sync  <= 2'b00;
      srdy_sync <= 2'b00;
    end else begin
      sdo_sync  <= {sdo_sync[0], EPL_SDO};
      srdy_sync <= {srdy_sync[0], EPL_SRDY};
    end
  end

  // Frame sequencer; all bus pins and response fields are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ph          <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      sh          <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      EPL_SCLK    <= 1'b0;
      EPL_SDI     <= 1'b0;
      EPL_SLE     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            write_q  <= cmd_write;
            wdata_q  <= cmd_wdata;
            EPL_SDI  <= cmd_write;               // command MSB goes out first
            sh       <= {cmd_addr, 25'h0};
            EPL_SLE  <= 1'b1;
            EPL_SCLK <= 1'b0;
            ph       <= '0;
            bit_cnt  <= '0;
            state    <= CMD;
          end
        end
        CMD, WDATA: begin
          if (ph_end) begin
            ph       <= '0;
            EPL_SCLK <= 1'b0;
            bit_cnt  <= bit_cnt + 6'd1;
            if (state == CMD && bit_cnt == 6'd7) begin
              bit_cnt <= '0;
              if (write_q) begin
                EPL_SDI <= wdata_q[31];
                sh      <= {wdata_q[30:0], 1'b0};
                state   <= WDATA;
              end else begin
                EPL_SDI <= 1'b0;
                to_cnt  <= '0;
                state   <= WAIT_RDY;
              end
            end else if (state == WDATA && bit_cnt == 6'd31) begin
              bit_cnt <= '0;
              EPL_SDI <= 1'b0;
              to_cnt  <= '0;
              state   <= WAIT_RDY;
            end else begin
              EPL_SDI <= sh[31];
              sh      <= {sh[30:0], 1'b0};
            end
          end else begin
            ph       <= ph + 9'd1;
            EPL_SCLK <= (ph >= PH_RISE);
          end
        end
        WAIT_RDY: begin
          // A ready seen on the final count still wins over the timeout.
          if (srdy_s) begin
            ph      <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
            if (write_q) begin
              rsp_valid   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_timeout <= 1'b0;
              state       <= DONE;
            end else begin
              state <= RDATA;
            end
          end else if (to_cnt == TO_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            state       <= DONE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        RDATA: begin
          if (ph_end) begin
            ph       <= '0;
            EPL_SCLK <= 1'b0;
            sh       <= {sh[30:0], sdo_s};
            if (bit_cnt == 6'd31) begin
              rsp_valid   <= 1'b1;
              rsp_rdata   <= {sh[30:0], sdo_s};
              rsp_timeout <= 1'b0;
              state       <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else begin
            ph       <= ph + 9'd1;
            EPL_SCLK <= (ph >= PH_RISE);
          end
        end
        DONE: begin
          EPL_SLE  <= 1'b0;
          EPL_SCLK <= 1'b0;
          EPL_SDI  <= 1'b0;
          ph       <= '0;
          state    <= GAP;
        end
        GAP: begin
          // Enforces a minimum SLE-low interval between frames.
          if (ph_end) begin
            ph    <= '0;
            state <= IDLE;
          end else begin
            ph <= ph + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epl_serial_host.sv
// Bench for epl_serial_host: a behavioural panel model decodes frames from the
// pin activity, answers with SRDY/SDO, and each test task checks the outcome.
module tb_epl_serial_host;
  localparam int CLK_DIV = 4;
  localparam int TIMEOUT = 1024;
  localparam int BIT_P   = 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        busy;
  logic        EPL_SCLK, EPL_SDI, EPL_SLE;
  logic        EPL_SDO = 1'b0;
  logic        EPL_SRDY = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  epl_serial_host #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .busy(busy), .EPL_SCLK(EPL_SCLK), .EPL_SDI(EPL_SDI), .EPL_SDO(EPL_SDO),
    .EPL_SLE(EPL_SLE), .EPL_SRDY(EPL_SRDY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Panel model configuration
  bit          dev_en = 1'b1;
  int          dev_delay = 0;
  logic [31:0] dev_data = '0;

  // Panel model / monitor state
  logic [39:0] cap = '0;
  int   n_rise = 0, n_tx = 0, tx_target = 8, period_err = 0, last_rise = 0;
  int   phase = 0, wcnt = 0, rx_k = 0, entry_cyc = 0;
  int   sle_rise_cyc = 0, sle_fall_cyc = 0, low_gap = 0, frame_cnt = 0;
  int   rsp_cnt = 0, rsp_cyc = 0, ready_bad = 0;
  logic [31:0] rsp_data = '0;
  logic rsp_to = 1'b0, sle_after_done = 1'b0;
  logic prev_sclk = 1'b0, prev_sle = 1'b0, prev_rsp = 1'b0;

  // Panel behaviour: collect host bits on SCLK rises, enter wait on the fall
  // after the last host bit, raise SRDY after dev_delay cycles, then shift
  // dev_data out MSB first, changing SDO on each SCLK fall.
  always @(negedge clk) begin
    if (prev_rsp) sle_after_done = EPL_SLE;
    prev_rsp = rsp_valid;
    if (rsp_valid) begin
      rsp_cnt++; rsp_data = rsp_rdata; rsp_to = rsp_timeout; rsp_cyc = cyc;
    end
    if (EPL_SLE && cmd_ready) ready_bad++;
    if (EPL_SLE && !prev_sle) begin
      low_gap = cyc - sle_fall_cyc;
      sle_rise_cyc = cyc; frame_cnt++;
      cap = '0; n_rise = 0; n_tx = 0; tx_target = 8; period_err = 0;
      phase = 0; rx_k = 0; wcnt = 0;
    end
    if (!EPL_SLE && prev_sle) sle_fall_cyc = cyc;
    if (!EPL_SLE) begin
      EPL_SRDY = 1'b0; EPL_SDO = 1'b0; phase = 0;
    end else begin
      if (EPL_SCLK && !prev_sclk) begin
        n_rise++;
        if (phase == 0 && n_tx < tx_target) begin
          if (n_tx > 0 && cyc - last_rise != BIT_P) period_err++;
          cap = {cap[38:0], EPL_SDI};
          if (n_tx == 0 && EPL_SDI) tx_target = 40;
          n_tx++; last_rise = cyc;
        end else if (phase == 2) rx_k++;
      end
      if (!EPL_SCLK && prev_sclk) begin
        if (phase == 0 && n_tx == tx_target) begin
          phase = 1; wcnt = 0; entry_cyc = cyc;
        end else if (phase == 2 && rx_k < 32) EPL_SDO = dev_data[31 - rx_k];
      end
      if (phase == 1) begin
        if (dev_en && wcnt == dev_delay) begin
          EPL_SRDY = 1'b1; EPL_SDO = dev_data[31];
          phase = (tx_target == 40) ? 3 : 2; rx_k = 0;
        end
        wcnt++;
      end
    end
    prev_sclk = EPL_SCLK;
    prev_sle  = EPL_SLE;
  end

  task automatic issue(input logic w, input logic [6:0] a, input logic [31:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int t = 0; t < 3000; t++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int prev, input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (rsp_cnt > prev) begin ok = 1'b1; break; end
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got %b want 0", cmd_ready); end
    n_tests++; if ({busy, rsp_valid, rsp_timeout, EPL_SCLK, EPL_SDI, EPL_SLE} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs got %b want 000000", {busy, rsp_valid, rsp_timeout, EPL_SCLK, EPL_SDI, EPL_SLE});
    end
    n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", cmd_ready); end
  endtask

  task automatic test_write;
    bit ok; int c0;
    dev_en = 1'b1; dev_delay = 3; c0 = rsp_cnt; ready_bad = 0;
    issue(1'b1, 7'h15, 32'hA5A50F0F, ok);
    wait_rsp(c0, 800, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL write_rsp got none want pulse"); end
    n_tests++; if (cap !== {8'h95, 32'hA5A50F0F}) begin n_fail++; $display("FAIL write_frame got %h want 95a5a50f0f", cap); end
    n_tests++; if (n_rise != 40 || period_err != 0) begin n_fail++; $display("FAIL write_sclk got rises=%0d perr=%0d want 40/0", n_rise, period_err); end
    n_tests++; if (entry_cyc - sle_rise_cyc != 40 * BIT_P) begin n_fail++; $display("FAIL write_sle_len got %0d want %0d", entry_cyc - sle_rise_cyc, 40 * BIT_P); end
    // SRDY driven mid-cycle at entry+3; two sync flops; DONE one cycle after it is seen.
    n_tests++; if (rsp_cyc - entry_cyc != dev_delay + 3) begin n_fail++; $display("FAIL write_latency got %0d want %0d", rsp_cyc - entry_cyc, dev_delay + 3); end
    n_tests++; if ({rsp_to, rsp_data} !== 33'h0) begin n_fail++; $display("FAIL write_rsp_fields got to=%b data=%h want 0/0", rsp_to, rsp_data); end
    n_tests++; if (rsp_cnt != c0 + 1 || ready_bad != 0) begin n_fail++; $display("FAIL write_handshake got rsp=%0d ready_in_frame=%0d want 1/0", rsp_cnt - c0, ready_bad); end
  endtask

  task automatic test_read;
    bit ok; int c0;
    dev_en = 1'b1; dev_delay = 20; dev_data = 32'h12345678; c0 = rsp_cnt;
    issue(1'b0, 7'h02, $urandom, ok);
    wait_rsp(c0, 1000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL read_rsp got none want pulse"); end
    n_tests++; if (cap[7:0] !== 8'h02) begin n_fail++; $display("FAIL read_cmd got %h want 02", cap[7:0]); end
    n_tests++; if (n_rise != 40) begin n_fail++; $display("FAIL read_rises got %0d want 40", n_rise); end
    n_tests++; if (rsp_data !== 32'h12345678 || rsp_to !== 1'b0) begin n_fail++; $display("FAIL read_data got %h to=%b want 12345678/0", rsp_data, rsp_to); end
    n_tests++; if (rsp_cyc - entry_cyc != dev_delay + 3 + 32 * BIT_P) begin n_fail++; $display("FAIL read_latency got %0d want %0d", rsp_cyc - entry_cyc, dev_delay + 3 + 32 * BIT_P); end
    n_tests++; if (sle_after_done !== 1'b0) begin n_fail++; $display("FAIL read_sle_after got %b want 0", sle_after_done); end
  endtask

  task automatic test_timeout;
    bit ok; int c0;
    dev_en = 1'b0; c0 = rsp_cnt;
    issue(1'b0, 7'($urandom), 32'h0, ok);
    wait_rsp(c0, 2000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL timeout_rsp got none want pulse"); end
    n_tests++; if (rsp_cyc - entry_cyc != TIMEOUT) begin n_fail++; $display("FAIL timeout_latency got %0d want %0d", rsp_cyc - entry_cyc, TIMEOUT); end
    n_tests++; if (rsp_to !== 1'b1 || rsp_data !== 32'h0) begin n_fail++; $display("FAIL timeout_fields got to=%b data=%h want 1/0", rsp_to, rsp_data); end
    n_tests++; if (sle_after_done !== 1'b0) begin n_fail++; $display("FAIL timeout_sle_after got %b want 0", sle_after_done); end
    dev_en = 1'b1;
  endtask

  task automatic test_back_to_back;
    int c0, f0; bit ok;
    dev_en = 1'b1; dev_delay = 2; dev_data = $urandom; c0 = rsp_cnt; f0 = frame_cnt; ready_bad = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h33;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (frame_cnt >= f0 + 2) begin ok = 1'b1; break; end
    end
    cmd_valid = 1'b0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_second_frame got none want frame"); end
    // SLE low for the whole GAP (2*CLK_DIV) plus the IDLE accept cycle.
    n_tests++; if (low_gap != BIT_P + 1) begin n_fail++; $display("FAIL b2b_gap got %0d want %0d", low_gap, BIT_P + 1); end
    wait_rsp(c0 + 1, 1000, ok);
    n_tests++; if (rsp_cnt != c0 + 2 || rsp_data !== dev_data) begin n_fail++; $display("FAIL b2b_rsp got n=%0d data=%h want 2/%h", rsp_cnt - c0, rsp_data, dev_data); end
    n_tests++; if (ready_bad != 0) begin n_fail++; $display("FAIL b2b_ready_in_frame got %0d want 0", ready_bad); end
  endtask

  task automatic test_reset_mid;
    bit ok; int c0;
    dev_en = 1'b1; dev_delay = 5; dev_data = $urandom; c0 = rsp_cnt;
    issue(1'b0, 7'h11, 32'h0, ok);
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (phase == 2 && rx_k == 10 && !EPL_SCLK) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach got none want rdata bit 10"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if ({EPL_SLE, EPL_SCLK, EPL_SDI, busy} !== 4'b0) begin n_fail++; $display("FAIL rstmid_pins got %b want 0000", {EPL_SLE, EPL_SCLK, EPL_SDI, busy}); end
    repeat (400) @(negedge clk);
    n_tests++; if (rsp_cnt != c0) begin n_fail++; $display("FAIL rstmid_no_rsp got %0d want 0", rsp_cnt - c0); end
    dev_data = $urandom;
    issue(1'b0, 7'h12, 32'h0, ok);
    wait_rsp(c0, 1000, ok);
    n_tests++; if (!ok || rsp_data !== dev_data || rsp_to !== 1'b0) begin n_fail++; $display("FAIL rstmid_recover got %h to=%b want %h/0", rsp_data, rsp_to, dev_data); end
  endtask

  task automatic test_srdy_boundary;
    bit ok; int c0;
    // Driving SRDY mid-cycle at entry+TIMEOUT-3 makes the synchronized copy
    // high exactly in the final count cycle (entry+TIMEOUT-1).
    dev_en = 1'b1; dev_delay = TIMEOUT - 3; dev_data = $urandom; c0 = rsp_cnt;
    issue(1'b0, 7'h40, 32'h0, ok);
    wait_rsp(c0, 2000, ok);
    n_tests++; if (!ok || rsp_to !== 1'b0 || rsp_data !== dev_data) begin n_fail++; $display("FAIL bound_last got to=%b data=%h want 0/%h", rsp_to, rsp_data, dev_data); end
    // One cycle later is too late: the timeout fires first.
    dev_delay = TIMEOUT - 2; c0 = rsp_cnt;
    issue(1'b0, 7'h41, 32'h0, ok);
    wait_rsp(c0, 2000, ok);
    n_tests++; if (!ok || rsp_to !== 1'b1 || rsp_cyc - entry_cyc != TIMEOUT) begin n_fail++; $display("FAIL bound_late got to=%b lat=%0d want 1/%0d", rsp_to, rsp_cyc - entry_cyc, TIMEOUT); end
  endtask

  task automatic test_random;
    bit ok; int c0; logic w; logic [6:0] a; logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      w = 1'($urandom); a = 7'($urandom); d = $urandom;
      dev_en = 1'b1; dev_delay = $urandom_range(0, 30); dev_data = $urandom; c0 = rsp_cnt;
      issue(w, a, d, ok);
      wait_rsp(c0, 1000, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rand%0d_rsp got none want pulse", i); end
      if (w) begin
        n_tests++; if (cap !== {w, a, d}) begin n_fail++; $display("FAIL rand%0d_wframe got %h want %h", i, cap, {w, a, d}); end
        n_tests++; if (rsp_data !== 32'h0 || rsp_to !== 1'b0) begin n_fail++; $display("FAIL rand%0d_wrsp got %h/%b want 0/0", i, rsp_data, rsp_to); end
      end else begin
        n_tests++; if (cap[7:0] !== {w, a}) begin n_fail++; $display("FAIL rand%0d_rcmd got %h want %h", i, cap[7:0], {w, a}); end
        n_tests++; if (rsp_data !== dev_data || rsp_to !== 1'b0) begin n_fail++; $display("FAIL rand%0d_rrsp got %h/%b want %h/0", i, rsp_data, rsp_to, dev_data); end
      end
      n_tests++; if (n_rise != 40 || period_err != 0) begin n_fail++; $display("FAIL rand%0d_sclk got rises=%0d perr=%0d want 40/0", i, n_rise, period_err); end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_srdy_boundary;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
